// File: rtl/tdm_demux2.sv
// tdm_demux2: receive side of a two-channel bit-interleaved TDM link.
// Slot k of a 2W-slot frame carries bit k/2 of channel (k mod 2), LSB first.
// A sync pulse marks slot 0. The block hunts for sync, then runs locked and
// delivers both channel words together once per complete frame.
//
// Handshake: there is no back-pressure. valid is a one-cycle pulse that
// qualifies the new q0/q1 pair; q0/q1 hold their value between pulses.
// en is a sample enable: with en low, din/sync are ignored and the frame
// position is frozen.
module tdm_demux2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         din,
  input  logic         sync,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic         valid,
  output logic         locked,
  output logic         frame_err
);

  localparam int            CW   = $clog2(2 * W);
  localparam logic [CW-1:0] LAST = CW'(2 * W - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sh0_q, sh0_d;
  logic [W-1:0]  sh1_q, sh1_d;
  logic [W-1:0]  q0_q, q0_d;
  logic [W-1:0]  q1_q, q1_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          locked_q, locked_d;

  // Shifted versions of the channel registers with din entering at the MSB;
  // after W shifts the first (LSB) bit has reached bit 0.
  logic [W-1:0]  sh0_in, sh1_in;
  assign sh0_in = {din, sh0_q[W-1:1]};
  assign sh1_in = {din, sh1_q[W-1:1]};

  // Next-state: frame tracking, channel assembly and output pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    q0_d     = q0_q;
    q1_d     = q1_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    if (en) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            sh0_d   = sh0_in;
            cnt_d   = ONE;
            state_d = RUN;
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            if (sync) begin
              sh0_d = sh0_in;
              cnt_d = ONE;
            end else begin
              // Missing sync at a frame boundary: lock is lost.
              ferr_d  = 1'b1;
              cnt_d   = '0;
              state_d = HUNT;
            end
          end else if (sync) begin
            // Early sync: drop the partial frame and restart on this slot.
            ferr_d = 1'b1;
            sh0_d  = sh0_in;
            cnt_d  = ONE;
          end else begin
            if (cnt_q[0]) sh1_d = sh1_in;
            else          sh0_d = sh0_in;
            if (cnt_q == LAST) begin
              // Last slot is always channel 1, so channel 0 is already whole.
              q0_d    = sh0_q;
              q1_d    = sh1_in;
              valid_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end
    locked_d = (state_d == RUN);
  end

  // State register with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      sh0_q    <= '0;
      sh1_q    <= '0;
      q0_q     <= '0;
      q1_q     <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh0_q    <= sh0_d;
      sh1_q    <= sh1_d;
      q0_q     <= q0_d;
      q1_q     <= q1_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      locked_q <= locked_d;
    end
  end

  assign q0        = q0_q;
  assign q1        = q1_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_tdm_demux2.sv
// tb_tdm_demux2: directed and randomized checks of tdm_demux2 (W=8)
// against a slot-list reference model and an expected-word queue.
module tb_tdm_demux2;

  localparam int W = 8;
  localparam int S = 2 * W;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         din = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] q0, q1;
  logic         valid, locked, frame_err;

  always #5 clk = ~clk;

  tdm_demux2 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din       (din),
    .sync      (sync),
    .q0        (q0),
    .q1        (q1),
    .valid     (valid),
    .locked    (locked),
    .frame_err (frame_err)
  );

  // ---------------- reference model ----------------
  // The model keeps the received slot bits of the current frame as a plain
  // array and rebuilds the channel words from it when the frame is full.
  int            n_assert = 0;
  int            n_fail   = 0;
  bit            m_locked = 0;
  int            m_pos    = 0;
  logic          m_bits [S];
  logic [W-1:0]  m_q0 = '0, m_q1 = '0;
  logic          m_valid = 0, m_ferr = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic s, input logic d);
    logic [W-1:0] w0, w1;
    m_valid = 0;
    m_ferr  = 0;
    if (!r) begin
      m_locked = 0;
      m_pos    = 0;
      m_q0     = '0;
      m_q1     = '0;
      exp_q.delete();
    end else if (e) begin
      if (!m_locked) begin
        if (s) begin
          m_bits[0] = d;
          m_pos     = 1;
          m_locked  = 1;
        end
      end else if (s) begin
        if (m_pos != 0) m_ferr = 1;
        m_bits[0] = d;
        m_pos     = 1;
      end else if (m_pos == 0) begin
        m_ferr   = 1;
        m_locked = 0;
      end else begin
        m_bits[m_pos] = d;
        m_pos++;
        if (m_pos == S) begin
          for (int i = 0; i < W; i++) begin
            w0[i] = m_bits[2*i];
            w1[i] = m_bits[2*i+1];
          end
          m_q0    = w0;
          m_q1    = w1;
          m_valid = 1;
          m_pos   = 0;
          exp_q.push_back({w1, w0});
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // One clock: drive inputs, take the edge, update the model, then check
  // every output 1 time unit after the edge.
  task automatic cyc(input logic r, input logic e, input logic s, input logic d);
    logic [2*W-1:0] w;
    rst_n = r;
    en    = e;
    sync  = s;
    din   = d;
    @(posedge clk);
    model_step(r, e, s, d);
    #1;
    chk("valid", valid, m_valid);
    chk("frame_err", frame_err, m_ferr);
    chk("locked", locked, m_locked);
    chk("q0_hold", q0, m_q0);
    chk("q1_hold", q1, m_q1);
    chk("valid_ferr_excl", valid & frame_err, 0);
    if (valid === 1'b1) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("sb_q0", q0, w[W-1:0]);
        chk("sb_q1", q1, w[2*W-1:W]);
      end
    end
  endtask

  // Send slots from..to of a frame carrying c0/c1; optionally stall with
  // en low for gap_len cycles after slot gap_at (random sync/din meanwhile).
  task automatic send_slots(input logic [W-1:0] c0, input logic [W-1:0] c1,
                            input int from, input int to,
                            input int gap_at, input int gap_len);
    logic b;
    for (int k = from; k <= to; k++) begin
      b = (k % 2) ? c1[k/2] : c0[k/2];
      cyc(1'b1, 1'b1, (k == 0), b);
      if (k == gap_at)
        for (int g = 0; g < gap_len; g++)
          cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mode, n;
    logic [W-1:0] r0, r1;

    // Reset for two cycles; all outputs must be zero.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst_q0", q0, 0);
    chk("rst_q1", q1, 0);
    chk("rst_locked", locked, 0);

    // No sync for 20 cycles: stays unlocked, nothing delivered.
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    chk("nosync_locked", locked, 0);
    chk("nosync_q0", q0, 0);

    // Two back-to-back frames.
    cyc(1'b1, 1'b1, 1'b1, 1'b1);          // slot 0 of A5/3C (A5 bit0 = 1)
    chk("lock_after_sync", locked, 1);
    send_slots(8'hA5, 8'h3C, 1, S - 1, -1, 0);
    chk("f1_valid", valid, 1);
    chk("f1_q0", q0, 8'hA5);
    chk("f1_q1", q1, 8'h3C);
    send_slots(8'hFF, 8'h00, 0, S - 1, -1, 0);
    chk("f2_valid", valid, 1);
    chk("f2_q0", q0, 8'hFF);
    chk("f2_q1", q1, 8'h00);

    // en low for 3 cycles after slot 5.
    send_slots(8'h81, 8'h7E, 0, S - 1, 5, 3);
    chk("gap_valid", valid, 1);
    chk("gap_q0", q0, 8'h81);
    chk("gap_q1", q1, 8'h7E);

    // Early sync at slot 9, then a complete frame.
    send_slots(8'hC3, 8'h5A, 0, 8, -1, 0);
    send_slots(8'h12, 8'h34, 0, 0, -1, 0);
    chk("early_ferr", frame_err, 1);
    chk("early_locked", locked, 1);
    chk("early_novalid", valid, 0);
    send_slots(8'h12, 8'h34, 1, S - 1, -1, 0);
    chk("early_q0", q0, 8'h12);
    chk("early_q1", q1, 8'h34);

    // Missing sync at slot 0 after a good frame.
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("miss_ferr", frame_err, 1);
    chk("miss_locked", locked, 0);
    chk("miss_q0", q0, 8'h12);
    chk("miss_q1", q1, 8'h34);

    // Reset at slot 10 of a frame, then a fresh frame.
    send_slots(8'hE7, 8'h99, 0, 9, -1, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("mid_rst_q0", q0, 0);
    chk("mid_rst_valid", valid, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_rst_locked", locked, 0);
    send_slots(8'h55, 8'hAA, 0, S - 1, -1, 0);
    chk("post_rst_q0", q0, 8'h55);
    chk("post_rst_q1", q1, 8'hAA);

    // Randomized mix of good frames, stalls, noise, truncation and resets.
    for (int it = 0; it < 80; it++) begin
      mode = $urandom_range(0, 9);
      r0 = W'($urandom);
      r1 = W'($urandom);
      if (mode <= 5) begin
        send_slots(r0, r1, 0, S - 1, int'($urandom_range(0, S - 1)), int'($urandom_range(0, 3)));
      end else if (mode <= 7) begin
        n = $urandom_range(3, 20);
        for (int i = 0; i < n; i++)
          cyc(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)));
      end else if (mode == 8) begin
        n = $urandom_range(1, 2);
        for (int i = 0; i < n; i++)
          cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        send_slots(r0, r1, 0, int'($urandom_range(0, S - 2)), -1, 0);
      end
    end

    // Drain: flush with one clean frame so any pending words are delivered.
    send_slots(8'h3A, 8'hC5, 0, S - 1, -1, 0);
    chk("final_q0", q0, 8'h3A);
    chk("final_q1", q1, 8'hC5);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux2.md
TDM_DEMUX2 -- requirements
Module: tdm_demux2

Interface
REQ-001 Parameter: W, default 8, bits per channel word; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: en  input  1  sample enable; din/sync ignored and all state held when low.
REQ-005 Port: din  input  1  serial TDM stream; two channels interleaved bit-by-bit, ch0 in even slots, ch1 in odd slots, LSB first.
REQ-006 Port: sync  input  1  frame marker; high only with slot 0 of a frame.
REQ-007 Port: q0  output  W  last complete channel-0 word.
REQ-008 Port: q1  output  W  last complete channel-1 word.
REQ-009 Port: valid  output  1  one-cycle pulse; q0/q1 updated this cycle.
REQ-010 Port: locked  output  1  high while in RUN state.
REQ-011 Port: frame_err  output  1  one-cycle pulse on framing violation.

Function
REQ-012 Frame: 2W slots; slot k carries bit k/2 of ch(k mod 2); this block is the receive-side inverse of a 2:1 select-toggling mux.
REQ-013 A "sample" is a rising edge with rst_n=1 and en=1; only samples advance the slot counter or shift data.
REQ-014 States: HUNT (unlocked), RUN (locked); slot counter 0..2W-1; one W-bit shift register per channel.
REQ-015 HUNT, sample with sync=0: discard din, stay HUNT.
REQ-016 HUNT, sample with sync=1: take din as slot 0 (ch0 bit 0), counter=1, go RUN.
REQ-017 RUN, sample at counter 1..2W-1 with sync=0: shift din into channel (counter mod 2) at bit counter/2; counter+1, wrapping 2W-1 -> 0.
REQ-018 RUN, sample at counter 2W-1: on the next edge q0/q1 load the assembled words and valid=1 for exactly one cycle (latency: 1 cycle after last bit sampled).
REQ-019 RUN, sample at counter 0 with sync=1: din taken as slot 0 of a new frame; normal.
REQ-020 RUN, sample at counter 0 with sync=0: frame_err pulse next cycle, din discarded, go HUNT (lock lost).
REQ-021 RUN, sample at counter 1..2W-1 with sync=1: frame_err pulse next cycle, partial frame discarded (no valid), din taken as slot 0, counter=1, stay RUN.
REQ-022 valid for a completed frame and acceptance of the next frame's slot 0 in the same cycle are both legal and independent.
REQ-023 en low mid-frame: counter, shift registers, state held; no valid, no frame_err; frame resumes on next sample.
REQ-024 q0/q1 hold value between valid pulses; never change without valid.
REQ-025 valid and frame_err are never high in the same cycle.
REQ-026 locked is a registered output, equal to (state==RUN).

Reset
REQ-027 rst_n=0 at a rising edge: state=HUNT, counter=0, shift registers=0, q0=q1=0, valid=0, locked=0, frame_err=0.
REQ-028 Reset mid-frame discards the partial frame; no valid or frame_err from it.
REQ-029 Reset has priority over en, sync and din.

Verification
REQ-030 W=8, rst_n low 2 cycles then high, en=1, sync=0 for 20 cycles -> locked=0, valid never, q0=q1=0.
REQ-031 Send frame ch0=0xA5, ch1=0x3C (sync at slot 0), then a second frame ch0=0xFF, ch1=0x00 back-to-back -> valid 1 cycle after slot 15 of each with q0/q1 = A5/3C then FF/00; locked=1 from the cycle after first sync.
REQ-032 Frame ch0=0x81, ch1=0x7E with en low for 3 cycles after slot 5 -> single valid, q0=0x81, q1=0x7E, no frame_err.
REQ-033 sync reasserted at slot 9 of a frame, followed by a full frame 0x12/0x34 -> frame_err 1 cycle, no valid for the broken frame, then valid with q0=0x12, q1=0x34, locked stays 1.
REQ-034 After a good frame, sync=0 at slot 0 -> frame_err 1 cycle, locked=0 next cycle, q0/q1 retain previous values.
REQ-035 rst_n low at slot 10 of a frame, released, new frame 0x55/0xAA -> all outputs 0 during reset, then valid with q0=0x55, q1=0xAA.
